// File: rtl/wb_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_queue_pkg
//  Purpose  : Shared types and widths for the write-back queue: the stored
//             entry layout, the drain FSM state encoding and the default
//             pointer/count widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package wb_queue_pkg;

  localparam int WBQ_XLEN  = 64;
  localparam int WBQ_RA_W  = 5;
  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_PTR_W = $clog2(WBQ_DEPTH);
  localparam int WBQ_CNT_W = $clog2(WBQ_DEPTH) + 1;

  // One queued GPR write. The layout follows the package widths, so the
  // queue's XLEN/RA_W parameters are expected to equal WBQ_XLEN/WBQ_RA_W.
  typedef struct packed {
    logic [WBQ_RA_W-1:0] rd;
    logic [WBQ_XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    WBQ_RUN   = 1'b0,
    WBQ_DRAIN = 1'b1
  } wbq_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_queue_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module   : wbq_fwd_match
//  Purpose  : Youngest-match forwarding for one source lookup. Scans the
//             occupied entries from oldest (rd_ptr) to youngest so the last
//             match wins.
//  Ports    : lk_rs    - lookup register address (0 never hits)
//             rd_ptr   - index of the oldest entry
//             count    - number of occupied entries
//             ent_rd   - flattened rd field of every slot
//             ent_data - flattened data field of every slot
//             hit/data - match flag and forwarded value (0 on miss)
//  Revision : 1.0 - initial release
// ============================================================================
module wbq_fwd_match
  import wb_queue_pkg::*;
#(
  parameter int XLEN  = WBQ_XLEN,
  parameter int DEPTH = WBQ_DEPTH,
  parameter int RA_W  = WBQ_RA_W
) (
  input  logic [RA_W-1:0]         lk_rs,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [DEPTH*RA_W-1:0]   ent_rd,
  input  logic [DEPTH*XLEN-1:0]   ent_data,
  output logic                    hit,
  output logic [XLEN-1:0]         data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    // Age k = 0 is the head; later (younger) matches overwrite earlier ones.
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (lk_rs != '0) &&
          (ent_rd[idx*RA_W +: RA_W] == lk_rs)) begin
        hit  = 1'b1;
        data = ent_data[idx*XLEN +: XLEN];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_queue
//  Purpose  : Write-back buffer between load/store and the GPR write port.
//             DEPTH-entry FIFO with valid/ready enqueue, one pop per accepted
//             GPR write, per-port forwarding of pending values and a drain
//             mode that empties the queue before a trap/CSR change/flush.
//  Ports    : in_*          - retiring result (valid/ready handshake)
//             gpr_*         - head entry towards the register file
//             lk_rs/lk_*    - NUM_SRC decode-stage source lookups
//             drain_req     - pulse: stop accepting and empty the queue
//             drain_done    - pulse: queue emptied after a drain request
//             count/empty/full - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int XLEN    = WBQ_XLEN,
  parameter int DEPTH   = WBQ_DEPTH,
  parameter int NUM_SRC = 2,
  parameter int RA_W    = WBQ_RA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RA_W-1:0]         in_rd,
  input  logic                    in_wen,
  input  logic                    in_csr_ren,
  input  logic [XLEN-1:0]         in_csr_rdata,
  input  logic [XLEN-1:0]         in_data,
  output logic                    gpr_wen,
  output logic [RA_W-1:0]         gpr_waddr,
  output logic [XLEN-1:0]         gpr_wdata,
  input  logic                    gpr_ready,
  input  logic [NUM_SRC*RA_W-1:0] lk_rs,
  output logic [NUM_SRC-1:0]      lk_hit,
  output logic [NUM_SRC*XLEN-1:0] lk_data,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  wbq_state_t       state;
  logic             accept;
  logic             push;
  logic             pop;

  logic [DEPTH*RA_W-1:0] ent_rd_flat;
  logic [DEPTH*XLEN-1:0] ent_data_flat;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  // Depends only on registered state, so a pop can never make room for a
  // push in the same cycle.
  assign in_ready = !full && (state == WBQ_RUN);
  assign accept   = in_valid && in_ready;
  // Requests that do not write a real register are consumed without storage.
  assign push     = accept && in_wen && (in_rd != '0);

  assign gpr_wen   = !empty;
  assign gpr_waddr = mem[rd_ptr].rd;
  assign gpr_wdata = mem[rd_ptr].data;
  assign pop       = gpr_wen && gpr_ready;

  // Entry storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: in_rd, data: (in_csr_ren ? in_csr_rdata : in_data)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: DRAIN blocks new requests while the register file keeps
  // popping; the first DRAIN cycle seen empty returns to RUN and raises a
  // one-cycle drain_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WBQ_RUN;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        WBQ_RUN: begin
          if (drain_req) state <= WBQ_DRAIN;
        end
        WBQ_DRAIN: begin
          if (empty) begin
            state      <= WBQ_RUN;
            drain_done <= 1'b1;
          end
        end
        default: state <= WBQ_RUN;
      endcase
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign ent_rd_flat[e*RA_W +: RA_W]   = mem[e].rd;
    assign ent_data_flat[e*XLEN +: XLEN] = mem[e].data;
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_lookup
    wbq_fwd_match #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .RA_W  (RA_W)
    ) u_match (
      .lk_rs    (lk_rs[p*RA_W +: RA_W]),
      .rd_ptr   (rd_ptr),
      .count    (count),
      .ent_rd   (ent_rd_flat),
      .ent_data (ent_data_flat),
      .hit      (lk_hit[p]),
      .data     (lk_data[p*XLEN +: XLEN])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_queue
//  Purpose  : Self-checking bench for wb_queue: directed vector table,
//             hand-written full/drain/reset sequences and randomized traffic
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_queue;

  localparam int XLEN = 64, DEPTH = 4, NUM_SRC = 2, RA_W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_wen, in_csr_ren, gpr_ready, drain_req;
  logic [4:0]  in_rd;
  logic [63:0] in_csr_rdata, in_data;
  logic [9:0]  lk_rs;
  logic        in_ready, gpr_wen, drain_done, empty, full;
  logic [4:0]  gpr_waddr;
  logic [63:0] gpr_wdata;
  logic [1:0]  lk_hit;
  logic [127:0] lk_data;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_csr_ren(in_csr_ren),
    .in_csr_rdata(in_csr_rdata), .in_data(in_data), .gpr_wen(gpr_wen),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .gpr_ready(gpr_ready),
    .lk_rs(lk_rs), .lk_hit(lk_hit), .lk_data(lk_data), .drain_req(drain_req),
    .drain_done(drain_done), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a plain queue of pending writes -------
  typedef struct { logic [4:0] rd; logic [63:0] data; } ment_t;
  ment_t mq[$];
  bit    mdrain = 0;
  bit    mdone  = 0;

  function automatic void mlook(input logic [4:0] a, output logic h, output logic [63:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0)
      foreach (mq[i])
        if (mq[i].rd == a) begin h = 1'b1; d = mq[i].data; end
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      mdrain = 0;
      mdone  = 0;
    end else begin
      bit acc, pp, fin;
      ment_t e;
      acc = in_valid && (mq.size() < DEPTH) && !mdrain;
      pp  = (mq.size() > 0) && gpr_ready;
      fin = mdrain && (mq.size() == 0);
      if (pp) void'(mq.pop_front());
      if (acc && in_wen && in_rd != 0) begin
        e.rd   = in_rd;
        e.data = in_csr_ren ? in_csr_rdata : in_data;
        mq.push_back(e);
      end
      mdone = fin;
      if (fin) mdrain = 0;
      else if (!mdrain && drain_req) mdrain = 1;
    end
  end

  // Compare every output against the model mid-cycle.
  initial forever begin
    logic h0, h1;
    logic [63:0] d0, d1;
    @(negedge clk);
    mlook(lk_rs[4:0], h0, d0);
    mlook(lk_rs[9:5], h1, d1);
    chk("m_count", count, mq.size());
    chk("m_empty", empty, mq.size() == 0);
    chk("m_full", full, mq.size() == DEPTH);
    chk("m_in_ready", in_ready, (mq.size() < DEPTH) && !mdrain);
    chk("m_gpr_wen", gpr_wen, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_waddr", gpr_waddr, mq[0].rd);
      chk("m_wdata", gpr_wdata, mq[0].data);
    end
    chk("m_hit", lk_hit, {h1, h0});
    chk("m_lkd0", lk_data[63:0], d0);
    chk("m_lkd1", lk_data[127:64], d1);
    chk("m_done", drain_done, mdone);
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic idle();
    in_valid = 0; in_rd = 0; in_wen = 0; in_csr_ren = 0;
    in_csr_rdata = 0; in_data = 0; gpr_ready = 0; lk_rs = 0; drain_req = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [63:0] d, input logic gr);
    idle();
    in_valid = 1; in_rd = rd; in_wen = 1; in_data = d; gpr_ready = gr;
    tick();
  endtask

  typedef struct {
    logic v; logic [4:0] rd; logic wen; logic csr; logic [63:0] csr_d; logic [63:0] d;
    logic gr; logic [4:0] l0; logic [4:0] l1;
    logic [2:0] e_cnt; logic e_wen; logic [4:0] e_wa; logic [63:0] e_wd;
    logic [1:0] e_hit; logic [63:0] e_d0; logic [63:0] e_d1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int lowc, pulses;
    bit seen;
    idle();
    tbl[0]  = '{1, 5, 1, 0, 0, 'h11, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 5, 3,      1, 1, 5, 'h11, 1, 'h11, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 5, 0,      1, 1, 5, 'h11, 1, 'h11, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0,      0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 7, 1, 0, 0, 'hA, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 7, 1, 0, 0, 'hB, 0, 7, 0,    1, 1, 7, 'hA, 1, 'hA, 0};
    tbl[6]  = '{1, 9, 1, 1, 'hC0FFEE, 1, 0, 7, 0, 2, 1, 7, 'hA, 1, 'hB, 0};
    tbl[7]  = '{1, 3, 0, 0, 0, 'h55, 0, 9, 7,   3, 1, 7, 'hA, 3, 'hC0FFEE, 'hB};
    tbl[8]  = '{1, 0, 1, 0, 0, 'h66, 0, 3, 9,   3, 1, 7, 'hA, 2, 0, 'hC0FFEE};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0,      3, 1, 7, 'hA, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0,      2, 1, 7, 'hB, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0,      1, 1, 9, 'hC0FFEE, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0};

    // Reset values while rst is held.
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_gpr_wen", gpr_wen, 0);
    chk("rst_hit", lk_hit, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    tick(); tick();
    rst = 0;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      idle();
      in_valid = tbl[i].v; in_rd = tbl[i].rd; in_wen = tbl[i].wen;
      in_csr_ren = tbl[i].csr; in_csr_rdata = tbl[i].csr_d; in_data = tbl[i].d;
      gpr_ready = tbl[i].gr; lk_rs = {tbl[i].l1, tbl[i].l0};
      #3;
      chk("t_count", count, tbl[i].e_cnt);
      chk("t_empty", empty, tbl[i].e_cnt == 0);
      chk("t_gpr_wen", gpr_wen, tbl[i].e_wen);
      chk("t_in_ready", in_ready, 1);
      if (tbl[i].e_wen) begin
        chk("t_waddr", gpr_waddr, tbl[i].e_wa);
        chk("t_wdata", gpr_wdata, tbl[i].e_wd);
      end
      chk("t_hit", lk_hit, tbl[i].e_hit);
      chk("t_lkd0", lk_data[63:0], tbl[i].e_d0);
      chk("t_lkd1", lk_data[127:64], tbl[i].e_d1);
      tick();
    end

    // Fill to full; no pass-through; pointer wrap.
    for (int i = 1; i <= 4; i++) push(5'(i), 64'(i * 16), 0);
    idle();
    in_valid = 1; in_rd = 5; in_wen = 1; in_data = 'h55; lk_rs = 10'd5;
    #3;
    chk("full_flag", full, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    chk("full_head", gpr_waddr, 1);
    tick();
    idle(); lk_rs = 10'd5;
    #3;
    chk("full_reject_cnt", count, 4);
    chk("full_reject_hit", lk_hit, 0);
    idle();
    in_valid = 1; in_rd = 6; in_wen = 1; in_data = 'h66; gpr_ready = 1;
    #3;
    chk("full_pop_no_pass", in_ready, 0);
    tick();
    idle(); in_valid = 1; in_rd = 8; in_wen = 1; in_data = 'h88; gpr_ready = 1;
    #3;
    chk("pp_count_before", count, 3);
    chk("pp_head_before", gpr_waddr, 2);
    tick();
    idle(); lk_rs = {5'd6, 5'd8};
    #3;
    chk("pp_count_after", count, 3);
    chk("pp_head_after", gpr_waddr, 3);
    chk("wrap_hit", lk_hit, 2'b01);
    chk("wrap_data", lk_data[63:0], 'h88);
    for (int i = 0; i < 3; i++) begin idle(); gpr_ready = 1; tick(); end
    idle();
    #3;
    chk("fill_emptied", count, 0);

    // Drain with three entries queued.
    for (int i = 10; i <= 12; i++) push(5'(i), 64'(i), 0);
    idle(); drain_req = 1; gpr_ready = 1;
    tick();
    lowc = 0; pulses = 0;
    for (int c = 0; c < 8; c++) begin
      idle(); gpr_ready = 1;
      #3;
      if (!in_ready) lowc++;
      if (drain_done) begin
        pulses++;
        chk("drain_done_cnt", count, 0);
        chk("drain_done_rdy", in_ready, 1);
      end
      tick();
    end
    chk("drain_low_cycles", lowc, 3);
    chk("drain_pulses", pulses, 1);

    // Accept in the same cycle as drain_req: the entry is drained too.
    push(14, 'h14, 0);
    idle(); drain_req = 1; in_valid = 1; in_rd = 15; in_wen = 1; in_data = 'h15;
    #3;
    chk("drain_acc_ready", in_ready, 1);
    tick();
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      idle(); gpr_ready = 1;
      #3;
      if (drain_done) begin seen = 1; chk("drain_acc_cnt", count, 0); end
      tick();
    end
    chk("drain_acc_seen", seen, 1);

    // Drain request while already empty.
    idle(); drain_req = 1;
    tick();
    idle();
    #3;
    chk("edrain_rdy0", in_ready, 0);
    chk("edrain_done0", drain_done, 0);
    tick();
    #3;
    chk("edrain_done1", drain_done, 1);
    chk("edrain_rdy1", in_ready, 1);
    tick();

    // Reset in the middle of a drain.
    push(20, 'h20, 0);
    push(21, 'h21, 0);
    idle(); drain_req = 1;
    tick();
    idle(); lk_rs = 10'd20;
    #3;
    chk("rd_in_drain", in_ready, 0);
    chk("rd_count2", count, 2);
    chk("rd_hit", lk_hit, 2'b01);
    rst = 1;
    #1;
    chk("rd_rst_count", count, 0);
    chk("rd_rst_empty", empty, 1);
    chk("rd_rst_full", full, 0);
    chk("rd_rst_ready", in_ready, 1);
    chk("rd_rst_gpr_wen", gpr_wen, 0);
    chk("rd_rst_hit", lk_hit, 0);
    chk("rd_rst_done", drain_done, 0);
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      idle(); gpr_ready = 1;
      #3;
      chk("rd_no_done", drain_done, 0);
      chk("rd_ready_after", in_ready, 1);
      tick();
    end

    // Randomized traffic; the model comparator does the checking.
    for (int i = 0; i < 1500; i++) begin
      idle();
      in_valid     = 1'($urandom_range(0, 1));
      in_rd        = 5'($urandom_range(0, 7));
      in_wen       = ($urandom_range(0, 7) != 0);
      in_csr_ren   = 1'($urandom_range(0, 1));
      in_csr_rdata = {$urandom, $urandom};
      in_data      = {$urandom, $urandom};
      gpr_ready    = ($urandom_range(0, 3) < (((i / 200) % 2) ? 1 : 3));
      lk_rs        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      drain_req    = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
